// File: rtl/ssram_pkg.sv
// Shared types and geometry for SSRAM bus masters.
// Holds the master FSM state enum and the register array dimensions.
package ssram_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ACCESS,
        ST_RECOVER
    } state_t;

endpackage

// File: rtl/ssram_addr_decode.sv
// One-hot row/column decoder for the 16x16 SSRAM register array.
// Ports: addr[7:0] in; row[15:0] = 1<<addr[7:4], column[15:0] = 1<<addr[3:0].
module ssram_addr_decode
    import ssram_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   column
);

    always_comb begin
        row    = '0;
        column = '0;
        row[addr[ADDR_W-1:ADDR_W/2]] = 1'b1;
        column[addr[ADDR_W/2-1:0]]   = 1'b1;
    end

endmodule

// File: rtl/ssram_master.sv
// Four-cycle SSRAM bus master: IDLE -> SELECT -> ACCESS -> RECOVER.
// Ports: clk, rst (sync, active high); user side req/wr/addr/wdata in,
// ready/ack/rdata out; bus side row/column one-hot selects, we/re
// strobes and the shared tristate data bus. All outputs registered.
module ssram_master
    import ssram_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              ready,
    output logic              ack,
    output logic [WIDTH-1:0]  rdata,
    output logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   column,
    output logic              we,
    output logic              re,
    inout  wire  [WIDTH-1:0]  data
);

    state_t              state_q,  state_d;
    logic                wr_q,     wr_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [WIDTH-1:0]    wdata_q,  wdata_d;
    logic [WIDTH-1:0]    rdata_q,  rdata_d;
    logic                ready_q,  ready_d;
    logic                ack_q,    ack_d;
    logic [ROWS-1:0]     row_q,    row_d;
    logic [COLS-1:0]     column_q, column_d;
    logic                we_q,     we_d;
    logic                re_q,     re_d;
    logic                oe_q,     oe_d;

    logic                sel_d;
    logic [ADDR_W-1:0]   dec_addr;
    logic [ROWS-1:0]     dec_row;
    logic [COLS-1:0]     dec_col;

    // Decode the address that will be latched after this edge, so the
    // selects come up registered in the very first SELECT cycle.
    assign dec_addr = (state_q == ST_IDLE) ? addr : addr_q;

    ssram_addr_decode u_dec (
        .addr   (dec_addr),
        .row    (dec_row),
        .column (dec_col)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SELECT;
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            ST_SELECT: state_d = ST_ACCESS;
            ST_ACCESS: begin
                state_d = ST_RECOVER;
                // Target has held its enable two cycles; bus is valid now.
                if (!wr_q) rdata_d = data;
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        sel_d    = (state_d == ST_SELECT) || (state_d == ST_ACCESS);
        ready_d  = (state_d == ST_IDLE);
        ack_d    = (state_d == ST_RECOVER);
        row_d    = sel_d ? dec_row : '0;
        column_d = sel_d ? dec_col : '0;
        we_d     = sel_d && wr_d;
        re_d     = sel_d && !wr_d;
        // Drive enable tracks we exactly, so it can never overlap re.
        oe_d     = we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            row_q    <= '0;
            column_q <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            row_q    <= row_d;
            column_q <= column_d;
            we_q     <= we_d;
            re_q     <= re_d;
            oe_q     <= oe_d;
        end
    end

    assign ready  = ready_q;
    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign row    = row_q;
    assign column = column_q;
    assign we     = we_q;
    assign re     = re_q;
    assign data   = oe_q ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ssram_master.sv
// Self-checking bench for ssram_master (WIDTH=8) with a 16x16 target
// register array on the shared bus and a transaction-level reference model.
module tb_ssram_master;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         wr = 1'b0;
    logic [7:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic         ready;
    logic         ack;
    logic [W-1:0] rdata;
    logic [15:0]  row;
    logic [15:0]  column;
    logic         we;
    logic         re;
    wire  [W-1:0] data;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ssram_master #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .ack    (ack),
        .rdata  (rdata),
        .row    (row),
        .column (column),
        .we     (we),
        .re     (re),
        .data   (data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 29 + 7);
    endfunction

    function automatic int low_bit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Target register array: enable-delay flop, latches on 2nd enabled edge.
    logic [W-1:0] arr [256];
    logic         arr_init = 1'b0;
    logic         en_dly = 1'b0;
    logic [7:0]   tgt_idx;
    logic         tgt_sel;
    logic [W-1:0] noise = 8'h5C;

    always_comb begin
        tgt_idx = 8'(low_bit(row) * 16 + low_bit(column));
        tgt_sel = (|row) && (|column) && (we || re);
    end

    // Target drives on reads; a background agent drives noise otherwise,
    // so any master drive outside a write corrupts the observed bus.
    assign data = we ? {W{1'bz}} : (re ? arr[tgt_idx] : noise);

    always @(posedge clk) begin
        if (!arr_init) begin
            for (int i = 0; i < 256; i++) arr[i] <= init_val(i);
            arr_init <= 1'b1;
        end
        if (rst) en_dly <= 1'b0;
        else begin
            en_dly <= tgt_sel;
            if (tgt_sel && en_dly && we) arr[tgt_idx] <= data;
        end
    end

    // Reference model: edge index of the last accepted request.
    int           cyc = 0;
    int           t_acc = -100;
    logic         m_wr = 1'b0;
    logic [7:0]   m_addr = '0;
    logic [W-1:0] m_wdata = '0;
    logic [W-1:0] m_rdata = '0;
    logic [W-1:0] ref_mem [256];
    logic         mem_init = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end
        if (rst) begin
            t_acc   <= -100;
            m_rdata <= '0;
        end else if (cyc + 1 - t_acc == 2) begin
            if (m_wr) ref_mem[m_addr] <= m_wdata;
            else      m_rdata <= ref_mem[m_addr];
        end else if (cyc + 1 - t_acc >= 4 && req) begin
            t_acc   <= cyc + 1;
            m_wr    <= wr;
            m_addr  <= addr;
            m_wdata <= wdata;
        end
    end

    int           d;
    logic         e_sel;
    logic [15:0]  e_row;
    logic [15:0]  e_col;
    logic [W-1:0] e_data;

    always @(negedge clk) begin
        if (chk_en) begin
            d      = cyc - t_acc;
            e_sel  = (d == 0) || (d == 1);
            e_row  = e_sel ? (16'h1 << m_addr[7:4]) : 16'h0;
            e_col  = e_sel ? (16'h1 << m_addr[3:0]) : 16'h0;
            e_data = (e_sel && m_wr) ? m_wdata :
                     (e_sel ? ref_mem[m_addr] : noise);
            chk("ready", 32'(ready), 32'(d >= 3));
            chk("ack", 32'(ack), 32'(d == 2));
            chk("row", 32'(row), 32'(e_row));
            chk("column", 32'(column), 32'(e_col));
            chk("we", 32'(we), 32'(e_sel && m_wr));
            chk("re", 32'(re), 32'(e_sel && !m_wr));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            chk("data", 32'(data), 32'(e_data));
            chk("row_pop", 32'($countones(row) <= 1), 1);
            chk("col_pop", 32'($countones(column) <= 1), 1);
            chk("we_re_excl", 32'(we && re), 0);
            if (re) chk("no_drive_re", 32'(data), 32'(arr[tgt_idx]));
        end
        noise <= 8'($urandom);
    end

    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [W-1:0] dv);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = dv;
        @(negedge clk);
        req   = 1'b0;
        wr    = 1'($urandom);
        addr  = 8'($urandom);
        wdata = 8'($urandom);
    endtask

    logic [15:0] t3_row [8];
    logic [W-1:0] saved;
    int n_ack;

    initial begin
        t3_row = '{16'h0001, 16'h0001, 16'h0, 16'h0,
                   16'h8000, 16'h8000, 16'h0, 16'h0};
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x5A <- 0xC3
        issue(1'b1, 8'h5A, 8'hC3);
        for (int i = 0; i < 2; i++) begin
            chk("t1_row", 32'(row), 'h0020);
            chk("t1_col", 32'(column), 'h0400);
            chk("t1_we", 32'(we), 1);
            chk("t1_data", 32'(data), 'hC3);
            chk("t1_ready", 32'(ready), 0);
            @(negedge clk);
        end
        chk("t1_ack", 32'(ack), 1);
        chk("t1_row_off", 32'(row), 0);
        @(negedge clk);
        chk("t1_mem", 32'(arr[8'h5A]), 'hC3);
        chk("t1_idle", 32'(ready), 1);

        // Read 0x5A; master wdata differs so a stray drive would show
        issue(1'b0, 8'h5A, 8'h3C);
        for (int i = 0; i < 2; i++) begin
            chk("t2_re", 32'(re), 1);
            chk("t2_we", 32'(we), 0);
            chk("t2_row", 32'(row), 'h0020);
            chk("t2_data", 32'(data), 'hC3);
            @(negedge clk);
        end
        chk("t2_ack", 32'(ack), 1);
        chk("t2_rdata", 32'(rdata), 'hC3);
        @(negedge clk);

        // req held high: writes to 0x00 then 0xFF
        req = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 8'h11;
        @(negedge clk);
        addr = 8'hFF; wdata = 8'h22;
        for (int i = 0; i < 8; i++) begin
            chk("t3_row", 32'(row), 32'(t3_row[i]));
            chk("t3_col", 32'(column), 32'(t3_row[i]));
            chk("t3_ack", 32'(ack), 32'(i == 2 || i == 6));
            chk("t3_ready", 32'(ready), 32'(i == 3 || i == 7));
            if (i == 4) req = 1'b0;
            @(negedge clk);
        end
        chk("t3_mem00", 32'(arr[8'h00]), 'h11);
        chk("t3_memff", 32'(arr[8'hFF]), 'h22);

        // Request pulsed during SELECT is dropped
        saved = arr[8'h77];
        issue(1'b1, 8'h33, 8'h44);
        req = 1'b1; wr = 1'b1; addr = 8'h77; wdata = 8'h88;
        @(negedge clk);
        req = 1'b0;
        n_ack = 0;
        repeat (6) begin
            n_ack += int'(ack);
            @(negedge clk);
        end
        chk("t4_acks", 32'(n_ack), 1);
        chk("t4_mem77", 32'(arr[8'h77]), 32'(saved));
        chk("t4_mem33", 32'(arr[8'h33]), 'h44);

        // Reset during ACCESS of a write to 0x10
        saved = arr[8'h10];
        issue(1'b1, 8'h10, 8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ready", 32'(ready), 1);
        chk("t5_ack", 32'(ack), 0);
        chk("t5_row", 32'(row), 0);
        chk("t5_col", 32'(column), 0);
        chk("t5_we_re", 32'({we, re}), 0);
        chk("t5_rdata", 32'(rdata), 0);
        n_ack = 0;
        repeat (3) begin
            n_ack += int'(ack);
            @(negedge clk);
        end
        chk("t5_acks", 32'(n_ack), 0);
        chk("t5_mem10", 32'(arr[8'h10]), 32'(saved));

        // Random traffic over a small address pool plus occasional resets
        repeat (400) begin
            rst   = ($urandom_range(0, 49) == 0);
            req   = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                    8'($urandom_range(0, 3) * 85);
            wdata = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        req = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
